// File: rtl/keypad_time_encoder_pkg.sv
// Shared types and constants for the keypad time-entry path.
// No logic: FSM encoding, BCD digit bundle and key-count constants only.
package keypad_time_pkg;

  localparam int BCD_W            = 4;
  localparam int NUM_KEYS         = 10;
  localparam int MAX_SEC_TENS_DEF = 5;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    DEBOUNCE     = 2'd1,
    WAIT_RELEASE = 2'd2
  } state_e;

  typedef struct packed {
    logic [BCD_W-1:0] min;
    logic [BCD_W-1:0] s_tens;
    logic [BCD_W-1:0] s_ones;
  } digits_t;

endpackage

// File: rtl/keypad_time_encoder_onehot.sv
// Two-flop keypad synchronizer with one-hot to BCD key code conversion.
// Latency: 2 cycles keypad to k_sync, code/single_key combinational from k_sync; no backpressure.
module keypad_onehot_encoder
  import keypad_time_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] keypad,
  output logic [NUM_KEYS-1:0] k_sync,
  output logic [BCD_W-1:0]    code,
  output logic                single_key
);

  logic [NUM_KEYS-1:0] meta_q, meta_d;
  logic [NUM_KEYS-1:0] sync_q, sync_d;
  logic [3:0]          nset;

  always_comb begin
    meta_d = keypad;
    sync_d = meta_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign k_sync = sync_q;

  // code is only meaningful when single_key is high
  always_comb begin
    code = '0;
    nset = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (sync_q[i]) begin
        code = BCD_W'(i);
        nset = nset + 4'd1;
      end
    end
    single_key = (nset == 4'd1);
  end

endmodule

// File: rtl/keypad_time_encoder.sv
// Debounces single digit keys and shifts them right-to-left into min:s_tens:s_ones.
// Latency: digits/pulse update DEBOUNCE_CYCLES+2 edges after a stable key is sampled; no backpressure.
module keypad_time_encoder
  import keypad_time_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int MAX_SEC_TENS    = MAX_SEC_TENS_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] keypad,
  input  logic       enable,
  input  logic       clear,
  output logic [3:0] s_ones,
  output logic [3:0] s_tens,
  output logic [3:0] min,
  output logic       digit_stb,
  output logic       digit_err
);

  localparam int              CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [NUM_KEYS-1:0] k_sync;
  logic [BCD_W-1:0]    code;
  logic                single_key;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [NUM_KEYS-1:0] pat_q, pat_d;
  digits_t             digits_q, digits_d;
  logic                stb_q, stb_d;
  logic                err_q, err_d;

  keypad_onehot_encoder u_onehot (
    .clk        (clk),
    .reset      (reset),
    .keypad     (keypad),
    .k_sync     (k_sync),
    .code       (code),
    .single_key (single_key)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pat_d    = pat_q;
    digits_d = digits_q;
    stb_d    = 1'b0;
    err_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (enable && single_key) begin
          state_d = DEBOUNCE;
          pat_d   = k_sync;
          cnt_d   = '0;
        end
      end
      DEBOUNCE: begin
        if ((k_sync != pat_q) || !enable) begin
          state_d = WAIT_RELEASE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = WAIT_RELEASE;
          // a seconds-units digit above the tens limit cannot legally move into s_tens
          if (digits_q.s_ones <= BCD_W'(MAX_SEC_TENS)) begin
            digits_d.min    = digits_q.s_tens;
            digits_d.s_tens = digits_q.s_ones;
            digits_d.s_ones = code;
            stb_d           = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WAIT_RELEASE: begin
        if (k_sync == '0) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // a key still held across clear must be released before it can count
    if (clear) begin
      digits_d = '0;
      stb_d    = 1'b0;
      err_d    = 1'b0;
      state_d  = (k_sync != '0) ? WAIT_RELEASE : IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      pat_q    <= '0;
      digits_q <= '0;
      stb_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pat_q    <= pat_d;
      digits_q <= digits_d;
      stb_q    <= stb_d;
      err_q    <= err_d;
    end
  end

  assign min       = digits_q.min;
  assign s_tens    = digits_q.s_tens;
  assign s_ones    = digits_q.s_ones;
  assign digit_stb = stb_q;
  assign digit_err = err_q;

endmodule

// File: tb/tb_keypad_time_encoder.sv
// Directed bench for keypad_time_encoder: digit entry, rejection, debounce, clear, enable and reset.
module tb_keypad_time_encoder;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] keypad;
  logic       enable;
  logic       clear;
  logic [3:0] s_ones;
  logic [3:0] s_tens;
  logic [3:0] min;
  logic       digit_stb;
  logic       digit_err;

  int total    = 0;
  int passed   = 0;
  int failed   = 0;
  int stb_cnt  = 0;
  int err_cnt  = 0;
  int both_cnt = 0;
  int idx;

  always #5 clk = ~clk;

  keypad_time_encoder #(
    .DEBOUNCE_CYCLES (4),
    .MAX_SEC_TENS    (5)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .keypad    (keypad),
    .enable    (enable),
    .clear     (clear),
    .s_ones    (s_ones),
    .s_tens    (s_tens),
    .min       (min),
    .digit_stb (digit_stb),
    .digit_err (digit_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
    stb_cnt  += int'(digit_stb);
    err_cnt  += int'(digit_err);
    both_cnt += int'(digit_stb & digit_err);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic zero_counts();
    stb_cnt = 0;
    err_cnt = 0;
  endtask

  // first = cycle index (0 = edge that first samples the key) of the first pulse, -1 if none
  task automatic press(input logic [9:0] k, input int hold, input int rel, output int first);
    first  = -1;
    keypad = k;
    for (int i = 0; i < hold; i++) begin
      tick();
      if (first < 0 && (digit_stb || digit_err)) first = i;
    end
    keypad = '0;
    for (int i = 0; i < rel; i++) tick();
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    tick();
  endtask

  initial begin
    reset  = 1'b1;
    keypad = '0;
    enable = 1'b1;
    clear  = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    chk("reset_min",    32'(min),       32'd0);
    chk("reset_s_tens", 32'(s_tens),    32'd0);
    chk("reset_s_ones", 32'(s_ones),    32'd0);
    chk("reset_stb",    32'(digit_stb), 32'd0);
    chk("reset_err",    32'(digit_err), 32'd0);
    reset = 1'b0;
    tick();

    // 1, 3, 0 -> 1:30
    zero_counts();
    press(10'h1 << 1, 8, 4, idx);
    chk("lat_key1", 32'(idx), 32'd6);
    chk("digits_after_1", 32'({min, s_tens, s_ones}), 32'h001);
    press(10'h1 << 3, 8, 4, idx);
    chk("lat_key3", 32'(idx), 32'd6);
    press(10'h1 << 0, 8, 4, idx);
    chk("lat_key0", 32'(idx), 32'd6);
    chk("digits_130", 32'({min, s_tens, s_ones}), 32'h130);
    chk("stb_cnt_130", 32'(stb_cnt), 32'd3);
    chk("err_cnt_130", 32'(err_cnt), 32'd0);

    // 9 then 5: 5 rejected because s_ones = 9 > 5
    do_clear();
    chk("clear_zero", 32'({min, s_tens, s_ones}), 32'h000);
    zero_counts();
    press(10'h1 << 9, 8, 4, idx);
    chk("digits_009", 32'({min, s_tens, s_ones}), 32'h009);
    press(10'h1 << 5, 8, 4, idx);
    chk("lat_reject5", 32'(idx), 32'd6);
    chk("digits_keep_009", 32'({min, s_tens, s_ones}), 32'h009);
    chk("stb_cnt_95", 32'(stb_cnt), 32'd1);
    chk("err_cnt_95", 32'(err_cnt), 32'd1);

    // two keys together: ignored
    zero_counts();
    press((10'h1 << 2) | (10'h1 << 7), 10, 4, idx);
    chk("multi_no_pulse", 32'(stb_cnt + err_cnt), 32'd0);
    chk("multi_digits", 32'({min, s_tens, s_ones}), 32'h009);
    do_clear();
    press(10'h1 << 4, 8, 4, idx);
    chk("digits_004", 32'({min, s_tens, s_ones}), 32'h004);

    // key 6 bounces, then held long: one digit only
    zero_counts();
    keypad = 10'h1 << 6;
    for (int i = 0; i < 2; i++) tick();
    keypad = '0;
    for (int i = 0; i < 2; i++) tick();
    keypad = 10'h1 << 6;
    for (int i = 0; i < 60; i++) tick();
    keypad = '0;
    for (int i = 0; i < 4; i++) tick();
    chk("bounce_stb_cnt", 32'(stb_cnt), 32'd1);
    chk("bounce_err_cnt", 32'(err_cnt), 32'd0);
    chk("digits_046", 32'({min, s_tens, s_ones}), 32'h046);

    // clear while key 8 held
    do_clear();
    press(10'h1 << 1, 8, 4, idx);
    press(10'h1 << 2, 8, 4, idx);
    chk("digits_012", 32'({min, s_tens, s_ones}), 32'h012);
    zero_counts();
    keypad = 10'h1 << 8;
    for (int i = 0; i < 3; i++) tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    chk("clear_held_digits", 32'({min, s_tens, s_ones}), 32'h000);
    chk("clear_held_no_pulse", 32'(stb_cnt + err_cnt), 32'd0);
    keypad = '0;
    for (int i = 0; i < 4; i++) tick();
    press(10'h1 << 8, 8, 4, idx);
    chk("repress8_lat", 32'(idx), 32'd6);
    chk("digits_008", 32'({min, s_tens, s_ones}), 32'h008);

    // enable low: no entry
    do_clear();
    zero_counts();
    enable = 1'b0;
    press(10'h1 << 3, 8, 4, idx);
    enable = 1'b1;
    chk("disabled_no_pulse", 32'(stb_cnt + err_cnt), 32'd0);
    chk("disabled_digits", 32'({min, s_tens, s_ones}), 32'h000);

    // enable drops mid-debounce: aborted
    keypad = 10'h1 << 3;
    for (int i = 0; i < 3; i++) tick();
    enable = 1'b0;
    tick();
    enable = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    keypad = '0;
    for (int i = 0; i < 4; i++) tick();
    chk("abort_no_pulse", 32'(stb_cnt + err_cnt), 32'd0);
    chk("abort_digits", 32'({min, s_tens, s_ones}), 32'h000);

    // reset mid-debounce, key kept held: fresh debounce from reset release
    press(10'h1 << 2, 8, 4, idx);
    chk("digits_002", 32'({min, s_tens, s_ones}), 32'h002);
    zero_counts();
    keypad = 10'h1 << 5;
    for (int i = 0; i < 4; i++) tick();
    reset = 1'b1;
    tick();
    chk("midreset_digits", 32'({min, s_tens, s_ones}), 32'h000);
    chk("midreset_stb", 32'(digit_stb), 32'd0);
    chk("midreset_err", 32'(digit_err), 32'd0);
    reset = 1'b0;
    press(10'h1 << 5, 10, 4, idx);
    chk("postreset_lat", 32'(idx), 32'd6);
    chk("digits_005", 32'({min, s_tens, s_ones}), 32'h005);
    chk("postreset_stb_cnt", 32'(stb_cnt), 32'd1);

    chk("stb_err_exclusive", 32'(both_cnt), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
